// File: rtl/full_adder.sv
// Registered WIDTH-bit full adder: {Cout,S} <= A + B + Cin, one cycle of latency.
// Optional macro FULL_ADDER_OVF_EN adds a registered two's-complement overflow output Ovf.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic prop;
    assign prop         = A[i] ^ B[i];
    assign sum[i]       = prop ^ carry[i];
    assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & prop);
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of the combinational ripple, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= sum;
      Cout <= carry[WIDTH];
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carries into and out of the sign bit disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Ovf <= 1'b0;
    end else begin
      Ovf <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 and WIDTH=8 instances against an arithmetic model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a1, b1, c1, s1, co1;
  logic [7:0] a8, b8, s8;
  logic       c8, co8;
`ifdef FULL_ADDER_OVF_EN
  logic       ov1, ov8;
`endif

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(c1), .S(s1), .Cout(co1)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(ov1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(c8), .S(s8), .Cout(co8)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(ov8)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed overflow from plain integer arithmetic on the two's-complement values.
  function automatic bit signed_ovf(input int a, input int b, input int c, input int w);
    int sa, sb, s;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    s  = sa + sb + c;
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction

  // Reference model: expected output register contents.
  int exp1, exp8;
  bit eo1, eo8;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp1 <= 0;
      exp8 <= 0;
      eo1  <= 1'b0;
      eo8  <= 1'b0;
    end else begin
      exp1 <= int'(a1) + int'(b1) + int'(c1);
      exp8 <= int'(a8) + int'(b8) + int'(c8);
      eo1  <= signed_ovf(int'(a1), int'(b1), int'(c1), 1);
      eo8  <= signed_ovf(int'(a8), int'(b8), int'(c8), 8);
    end
  end

  // Continuous comparison on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("w1_model", 64'({co1, s1}), 64'(exp1));
      check("w8_model", 64'({co8, s8}), 64'(exp8));
`ifdef FULL_ADDER_OVF_EN
      check("w1_ovf_model", 64'(ov1), 64'(eo1));
      check("w8_ovf_model", 64'(ov8), 64'(eo8));
`endif
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] res;
    logic       ovf;
  } vec8_t;

  initial begin
    logic [1:0] tbl1 [8];
    vec8_t      dir8 [6];
    tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    dir8 = '{
      '{8'hFF, 8'h00, 1'b1, 9'h100, 1'b0},
      '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0},
      '{8'h00, 8'h00, 1'b0, 9'h000, 1'b0},
      '{8'h0F, 8'h01, 1'b0, 9'h010, 1'b0},
      '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1},
      '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1}
    };

    rst_n = 1'b0;
    {a1, b1, c1} = '0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_s1", 64'(s1), 64'd0);
    check("reset_co1", 64'(co1), 64'd0);
    check("reset_s8", 64'(s8), 64'd0);
    check("reset_co8", 64'(co8), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // WIDTH=1 exhaustive sweep, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a1, b1, c1} = 3'(i);
      @(posedge clk);
      #1 check($sformatf("w1_sweep_%0d", i), 64'({co1, s1}), 64'(tbl1[i]));
    end

    // WIDTH=8 carry chain and back-to-back vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a8 = dir8[i].a; b8 = dir8[i].b; c8 = dir8[i].c;
      @(posedge clk);
      #1 check($sformatf("w8_dir_%0d", i), 64'({co8, s8}), 64'(dir8[i].res));
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("w8_dir_ovf_%0d", i), 64'(ov8), 64'(dir8[i].ovf));
`endif
    end

`ifdef FULL_ADDER_OVF_EN
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    @(posedge clk);
    #1 check("w8_ovf_wrap_sum", 64'({co8, s8}), 64'h100);
    check("w8_ovf_wrap_ovf", 64'(ov8), 64'd0);
`endif

    // Mid-cycle input change must not reach the outputs before the next edge.
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h04; c8 = 1'b0;
    @(posedge clk);
    #1 check("lat_first", 64'({co8, s8}), 64'h007);
    #2 a8 = 8'h50;
    #1 check("lat_hold", 64'({co8, s8}), 64'h007);
    @(negedge clk);
    check("lat_hold_negedge", 64'({co8, s8}), 64'h007);
    @(posedge clk);
    #1 check("lat_update", 64'({co8, s8}), 64'h054);

    // Asynchronous reset between edges, synchronous release.
    @(negedge clk);
    {a1, b1, c1} = 3'b111;
    @(posedge clk);
    #1 check("rst_pre", 64'({co1, s1}), 64'h3);
    #2 rst_n = 1'b0;
    #1 check("rst_async_w1", 64'({co1, s1}), 64'h0);
    check("rst_async_w8", 64'({co8, s8}), 64'h0);
    @(posedge clk);
    #1 check("rst_hold", 64'({co1, s1}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_released", 64'({co1, s1}), 64'h0);
    @(posedge clk);
    #1 check("rst_first_capture", 64'({co1, s1}), 64'h3);

    // Randomized traffic checked by the model every cycle.
    repeat (300) begin
      @(negedge clk);
      {a1, b1, c1} = 3'($urandom_range(0, 7));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
